mips_multicycle_ctrl: RTL

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/MEM/EXEC/WB sequencing and
// datapath control decode. Optional memory wait: MULTICYCLE_MEMWAIT_EN.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   Op, Funct           : opcode and R-type function field from the IR
//   Zero                : ALU zero flag (used in BRANCH)
//   MemReady            : memory handshake (only with MULTICYCLE_MEMWAIT_EN)
//   PCEn .. IllegalOp   : 1-bit datapath controls
//   ALUSrcB, PCSrc      : 2-bit mux selects
//   ALUControl          : 4-bit ALU operation
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       ExtOp,
   output logic       ShamtSrc,
   output logic       IllegalOp,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [3:0] ALUControl
);

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1101;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   is_rtype;
   logic   mem_ok;
   logic   r_legal;
   logic   r_shv;
   logic [3:0] r_alu;

`ifdef MULTICYCLE_MEMWAIT_EN
   assign mem_ok = MemReady;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = MemReady;
   assign mem_ok = 1'b1;
`endif

   // R-type function decode
   always_comb begin
      r_legal = 1'b1;
      r_shv   = 1'b0;
      r_alu   = ALU_ADD;
      case (Funct)
         6'b100000, 6'b100001: r_alu = ALU_ADD;
         6'b100010, 6'b100011: r_alu = ALU_SUB;
         6'b100100:            r_alu = ALU_AND;
         6'b100101:            r_alu = ALU_OR;
         6'b100110:            r_alu = ALU_XOR;
         6'b000000:            r_alu = ALU_SLL;
         6'b000010:            r_alu = ALU_SRL;
         6'b000011:            r_alu = ALU_SRA;
         6'b000100: begin r_alu = ALU_SLL; r_shv = 1'b1; end
         6'b000110: begin r_alu = ALU_SRL; r_shv = 1'b1; end
         6'b000111: begin r_alu = ALU_SRA; r_shv = 1'b1; end
         default:              r_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:  if (mem_ok) state_nxt = DECODE;
         DECODE: begin
            case (Op)
               OP_LW, OP_SW:  state_nxt = MEMADR;
               OP_R:          state_nxt = EXEC_R;
               OP_ADDI, OP_ADDIU, OP_ANDI,
               OP_ORI, OP_XORI, OP_LUI:
                              state_nxt = EXEC_I;
               OP_BEQ, OP_BNE: state_nxt = BRANCH;
               OP_J:          state_nxt = JUMP;
               default:       state_nxt = FETCH;
            endcase
         end
         MEMADR: state_nxt = (Op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  if (mem_ok) state_nxt = MEMWB;
         MEMWR:  if (mem_ok) state_nxt = FETCH;
         EXEC_R: state_nxt = r_legal ? ALUWB : FETCH;
         EXEC_I: state_nxt = ALUWB;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         is_rtype <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DECODE)
            is_rtype <= (Op == OP_R);
      end
   end

   // Outputs are decoded from the state register rather than registered,
   // since BRANCH must see the live Zero flag from this cycle's subtract.
   always_comb begin
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ExtOp      = 1'b0;
      ShamtSrc   = 1'b0;
      IllegalOp  = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      ALUControl = ALU_ADD;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ok;
            PCEn    = mem_ok;
         end
         DECODE: begin
            ALUSrcB   = 2'b11;
            ExtOp     = 1'b1;
            IllegalOp = (state_nxt == FETCH);
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXEC_R: begin
            ALUSrcA    = 1'b1;
            ALUControl = r_alu;
            ShamtSrc   = r_shv;
            IllegalOp  = ~r_legal;
         end
         EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtOp   = (Op == OP_ADDI) || (Op == OP_ADDIU);
            case (Op)
               OP_ANDI: ALUControl = ALU_AND;
               OP_ORI:  ALUControl = ALU_OR;
               OP_XORI: ALUControl = ALU_XOR;
               OP_LUI:  ALUControl = ALU_LUI;
               default: ALUControl = ALU_ADD;
            endcase
         end
         ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = is_rtype;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 2'b01;
            PCEn       = ((Op == OP_BEQ) & Zero) | ((Op == OP_BNE) & ~Zero);
         end
         JUMP: begin
            PCSrc = 2'b10;
            PCEn  = 1'b1;
         end
         default: ;
      endcase
      // Reset suppresses every write strobe regardless of state.
      if (rst) begin
         PCEn      = 1'b0;
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         IRWrite   = 1'b0;
         RegWrite  = 1'b0;
         IllegalOp = 1'b0;
      end
   end

endmodule
